// File: rtl/facedet_pkg.sv
// facedet_pkg: definitions shared by the gray unpacker and its pixel mapper.
//   PIX_W        - bits per gray pixel
//   PIX_PER_WORD - gray pixels packed into one input word
//   state_t      - unpacker FSM state (EMPTY: no word held, UNPACK: word held)
package facedet_pkg;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic {
        EMPTY  = 1'b0,
        UNPACK = 1'b1
    } state_t;

endpackage

// File: rtl/gray_map.sv
// gray_map: purely combinational gray-to-channel mapping.
//   i_gray   - selected 8-bit gray pixel
//   i_thresh - binarisation threshold (present only with GRAY_UNPACK_THRESH_EN)
//   o_pix    - value driven onto each of R, G and B
// Build option: GRAY_UNPACK_THRESH_EN selects a binary output
// (FF when gray >= thresh, else 00); otherwise the gray value passes through.
module gray_map
    import facedet_pkg::*;
(
    input  logic [PIX_W-1:0] i_gray,
`ifdef GRAY_UNPACK_THRESH_EN
    input  logic [PIX_W-1:0] i_thresh,
`endif
    output logic [PIX_W-1:0] o_pix
);

`ifdef GRAY_UNPACK_THRESH_EN
    assign o_pix = (i_gray >= i_thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    assign o_pix = i_gray;
`endif

endmodule

// File: rtl/gray_unpack_rgb.sv
// gray_unpack_rgb: unpacks 32-bit words of four gray pixels into one RGB
// pixel per cycle and tags each pixel with frame position markers.
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_data/in_valid/in_ready   - packed word input (pixel 0 in [7:0])
//   R/G/B/out_valid/out_ready   - pixel output stream
//   sof/eol/eof         - start of frame / end of line / end of frame
//   thresh              - threshold (only with GRAY_UNPACK_THRESH_EN)
//   o_dbg_state, o_dbg_idx      - FSM state and pixel index, for observation
// Build option: GRAY_UNPACK_THRESH_EN adds the thresh port and binarises
// the output through gray_map.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holding valid keeps its data stable until ready,
// and while out_valid && !out_ready every pixel output and marker is held.
module gray_unpack_rgb
    import facedet_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [PIX_W-1:0]     R,
    output logic [PIX_W-1:0]     G,
    output logic [PIX_W-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sof,
    output logic                 eol,
    output logic                 eof,
`ifdef GRAY_UNPACK_THRESH_EN
    input  logic [PIX_W-1:0]     thresh,
`endif
    output state_t               o_dbg_state,
    output logic [1:0]           o_dbg_idx
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [31:0]      r_word, w_word_nxt;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             w_accept, w_xfer, w_last_col, w_last_row;
    logic [PIX_W-1:0] w_gray, w_mapped;

    assign out_valid = (r_state == UNPACK);
    // The next word is taken in the same cycle the last pixel leaves, so a
    // continuous input stream produces no bubble between words.
    assign in_ready  = (r_state == EMPTY) || ((r_idx == 2'd3) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_idx   <= 2'd0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = UNPACK;
                    w_idx_nxt   = 2'd0;
                    w_word_nxt  = in_data;
                end
            end
            UNPACK: begin
                if (w_xfer) begin
                    if (r_idx == 2'd3) begin
                        w_idx_nxt = 2'd0;
                        if (w_accept) begin
                            w_word_nxt = in_data;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // ---------------- frame position ----------------
    assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ---------------- pixel path ----------------
    assign w_gray = r_word[{r_idx, 3'b000} +: PIX_W];

`ifdef GRAY_UNPACK_THRESH_EN
    // Threshold is captured whenever a new pixel is presented, so a stalled
    // pixel keeps the mapping it was shown with.
    logic [PIX_W-1:0] r_thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= '0;
        end else if (w_accept || w_xfer) begin
            r_thresh <= thresh;
        end
    end

    gray_map u_map (
        .i_gray   (w_gray),
        .i_thresh (r_thresh),
        .o_pix    (w_mapped)
    );
`else
    gray_map u_map (
        .i_gray (w_gray),
        .o_pix  (w_mapped)
    );
`endif

    // Gating with out_valid keeps every pixel output at zero while idle or
    // in reset, even when the mapping of a zero word would be nonzero.
    assign R   = out_valid ? w_mapped : '0;
    assign G   = out_valid ? w_mapped : '0;
    assign B   = out_valid ? w_mapped : '0;
    assign sof = out_valid && (r_col == '0) && (r_row == '0);
    assign eol = out_valid && w_last_col;
    assign eof = out_valid && w_last_col && w_last_row;

    assign o_dbg_state = r_state;
    assign o_dbg_idx   = r_idx;

endmodule

// File: tb/tb_gray_unpack_rgb.sv
// tb_gray_unpack_rgb: directed bench for gray_unpack_rgb (8x2 frame).
// A reference model (queue of pending pixels plus a frame pixel count) is
// compared against the DUT on every falling edge; directed tests add
// hand-computed expectations on the logged pixel stream.
// Build option: GRAY_UNPACK_THRESH_EN enables the threshold test.
module tb_gray_unpack_rgb;
    import facedet_pkg::*;

    localparam int W = 8;
    localparam int H = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  R, G, B;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sof, eol, eof;
    state_t      dbg_state;
    logic [1:0]  dbg_idx;
`ifdef GRAY_UNPACK_THRESH_EN
    logic [7:0]  thresh = 8'h30;
`endif

    gray_unpack_rgb #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .R           (R),
        .G           (G),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
`ifdef GRAY_UNPACK_THRESH_EN
        .thresh      (thresh),
`endif
        .o_dbg_state (dbg_state),
        .o_dbg_idx   (dbg_idx)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pmap(input logic [7:0] px);
`ifdef GRAY_UNPACK_THRESH_EN
        return (px >= thresh) ? 8'hFF : 8'h00;
`else
        return px;
`endif
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] exp_q[$];
    int         pos = 0;
    logic [7:0] obs_px[$];
    logic [2:0] obs_fl[$];
    int         obs_cyc[$];
    int         acc_cyc[$];

    always @(negedge clk) begin
        int sz, col, row;
        logic [7:0] em;
        logic ev, acc, xf;
        if (!rst_n) begin
            check("rst_valid", out_valid, 1'b0);
            check("rst_rgb", {R, G, B}, 24'h0);
            check("rst_marks", {sof, eol, eof}, 3'b000);
            exp_q.delete();
            pos = 0;
        end else begin
            sz = exp_q.size();
            ev = (sz != 0);
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, (sz == 0) || (sz == 1 && out_ready));
            check("state", dbg_state, ev ? UNPACK : EMPTY);
            if (ev) begin
                em  = pmap(exp_q[0]);
                col = pos % W;
                row = (pos / W) % H;
                check("rgb", {R, G, B}, {em, em, em});
                check("sof", sof, (col == 0) && (row == 0));
                check("eol", eol, col == W - 1);
                check("eof", eof, (col == W - 1) && (row == H - 1));
                check("idx", dbg_idx, 4 - sz);
            end else begin
                check("idle_rgb", {R, G, B}, 24'h0);
                check("idle_marks", {sof, eol, eof}, 3'b000);
            end
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf && ev) begin
                obs_px.push_back(R);
                obs_fl.push_back({sof, eol, eof});
                obs_cyc.push_back(cyc);
                void'(exp_q.pop_front());
                pos++;
            end
            if (acc) begin
                for (int k = 0; k < 4; k++) exp_q.push_back(in_data[k*8 +: 8]);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] wr_q[$];

    function automatic logic [31:0] mk_word(input int base, input int n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(base + n * 4 + k);
        return w;
    endfunction

    task automatic clear_logs();
        obs_px.delete(); obs_fl.delete(); obs_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    // Sends wr_q with cyclic valid/ready patterns; valid is held until taken.
    task automatic run_stream(input logic [15:0] ordy_pat, input logic [15:0] ivld_pat, input int max_cyc);
        int w = 0;
        int c = 0;
        logic acc;
        logic pend = 1'b0;
        while ((w < wr_q.size() || exp_q.size() != 0) && c < max_cyc) begin
            in_valid  = (w < wr_q.size()) && (pend || ivld_pat[c % 16]);
            in_data   = (w < wr_q.size()) ? wr_q[w] : 32'h0;
            out_ready = ordy_pat[c % 16];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            pend = in_valid && !acc;
            if (acc) w++;
            c++;
        end
        in_valid = 1'b0;
        check("stream_done", (w == wr_q.size()) && (exp_q.size() == 0), 1'b1);
    endtask

    // ---------------- tests ----------------
    logic [7:0] lit4[4];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);

        // single word, four pixels back to back, one cycle latency
        @(posedge clk); #1;
        clear_logs();
        wr_q = '{32'h44332211};
        run_stream(16'hFFFF, 16'hFFFF, 50);
        lit4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("t1_count", obs_px.size(), 4);
        for (int i = 0; i < 4 && i < obs_px.size(); i++) check("t1_pix", obs_px[i], pmap(lit4[i]));
        if (obs_cyc.size() == 4 && acc_cyc.size() == 1) begin
            check("t1_latency", obs_cyc[0] - acc_cyc[0], 1);
            check("t1_gapless", obs_cyc[3] - obs_cyc[0], 3);
            check("t1_sof", obs_fl[0], 3'b100);
        end

        // full 8x2 frame plus a wrap into the next frame, no gaps
        do_reset();
        clear_logs();
        wr_q.delete();
        for (int n = 0; n < 5; n++) wr_q.push_back(mk_word(0, n));
        run_stream(16'hFFFF, 16'hFFFF, 100);
        check("t2_count", obs_px.size(), 20);
        for (int n = 0; n < 20 && n < obs_px.size(); n++) begin
            check("t2_pix", obs_px[n], pmap(8'(n)));
            check("t2_flags", obs_fl[n], (n == 0 || n == 16) ? 3'b100 :
                                         (n == 7) ? 3'b010 : (n == 15) ? 3'b011 : 3'b000);
        end
        if (obs_cyc.size() == 20) check("t2_gapless", obs_cyc[19] - obs_cyc[0], 19);

        // stall at idx=1 for five cycles
        do_reset();
        in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_rgb", R, pmap(8'h22));
            check("t3_hold_idx", dbg_idx, 2'd1);
            check("t3_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_resume_idx1", R, pmap(8'h22));
        @(negedge clk);
        check("t3_resume_idx2", R, pmap(8'h33));
        check("t3_resume_idx", dbg_idx, 2'd2);
        repeat (3) begin @(posedge clk); #1; end

        // reset mid-word after two pixels
        do_reset();
        in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("t4_pre_idx", dbg_idx, 2'd2);
        rst_n = 1'b0;
        #1;
        check("t4_valid", out_valid, 1'b0);
        check("t4_rgb", {R, G, B}, 24'h0);
        check("t4_marks", {sof, eol, eof}, 3'b000);
        check("t4_idx", dbg_idx, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h88776655;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_pix", R, pmap(8'h55));
        check("t4_sof", sof, 1'b1);
        repeat (5) begin @(posedge clk); #1; end

        // mixed valid/ready patterns across word boundaries
        do_reset();
        clear_logs();
        wr_q.delete();
        for (int n = 0; n < 4; n++) wr_q.push_back(mk_word(8'hA0, n));
        run_stream(16'b1011_0111_1101_1110, 16'b1101_1011_0110_1111, 300);
        check("t5_count", obs_px.size(), 16);
        for (int n = 0; n < 16 && n < obs_px.size(); n++) check("t5_pix", obs_px[n], pmap(8'(8'hA0 + n)));

`ifdef GRAY_UNPACK_THRESH_EN
        // binarisation at 0x80
        do_reset();
        thresh = 8'h80;
        clear_logs();
        wr_q = '{32'h817F8000};
        run_stream(16'hFFFF, 16'hFFFF, 50);
        lit4 = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        check("t6_count", obs_px.size(), 4);
        for (int i = 0; i < 4 && i < obs_px.size(); i++) check("t6_pix", obs_px[i], lit4[i]);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
